// File: rtl/gps_config_sequencer.sv
// gps_config_sequencer: after power-up, waits out a startup delay and then
// streams LF-terminated command sentences from a registered byte ROM into the
// GPS UART transmitter. Each sentence must be acknowledged by the NMEA parser;
// a NAK or a timeout resends the sentence until the retry budget runs out.
module gps_config_sequencer #(
  parameter int SYSCLK_FREQ    = 100_000_000,
  parameter int STARTUP_MS     = 1000,
  parameter int ACK_TIMEOUT_MS = 500,
  parameter int MAX_RETRIES    = 3,
  parameter int NUM_CMDS       = 4
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       start,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       ack_valid,
  input  logic       ack_ok,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] cmd_index,
  output logic [1:0] retry_cnt
);

  localparam int STARTUP_CYCLES = SYSCLK_FREQ / 1000 * STARTUP_MS;
  localparam int ACK_CYCLES     = SYSCLK_FREQ / 1000 * ACK_TIMEOUT_MS;
  localparam int MAX_CYCLES     = (STARTUP_CYCLES > ACK_CYCLES) ? STARTUP_CYCLES : ACK_CYCLES;
  localparam int TIMER_W        = $clog2(MAX_CYCLES + 1);

  localparam logic [TIMER_W-1:0] STARTUP_LAST = TIMER_W'(STARTUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ACK_LAST     = TIMER_W'(ACK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX    = TIMER_W'(MAX_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam logic [7:0]         LAST_CMD     = 8'(NUM_CMDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    STARTUP,
    FETCH,
    LOAD,
    SEND,
    WAIT_ACK,
    DONE,
    ERROR
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [7:0]         cmd_start;

  // Sequencer FSM with all outputs registered; the timer free-runs (saturating)
  // and is only meaningful in STARTUP and WAIT_ACK, where it is freshly cleared.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state     <= STARTUP;
      timer     <= '0;
      cmd_start <= 8'h00;
      rom_addr  <= 8'h00;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      cmd_index <= 8'h00;
      retry_cnt <= 2'd0;
      done      <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b1;
    end else begin
      if (timer != TIMER_MAX) begin
        timer <= timer + TIMER_ONE;
      end
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            cmd_index <= 8'h00;
            retry_cnt <= 2'd0;
            rom_addr  <= 8'h00;
            cmd_start <= 8'h00;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        STARTUP: begin
          if (timer == STARTUP_LAST) begin
            rom_addr  <= 8'h00;
            cmd_start <= 8'h00;
            state     <= FETCH;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          tx_data  <= rom_data;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (tx_data == 8'h0A) begin
              timer <= '0;
              state <= WAIT_ACK;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= FETCH;
            end
          end
        end
        WAIT_ACK: begin
          if (ack_valid && ack_ok) begin
            if (cmd_index == LAST_CMD) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              cmd_index <= cmd_index + 8'd1;
              retry_cnt <= 2'd0;
              rom_addr  <= rom_addr + 8'd1;
              cmd_start <= rom_addr + 8'd1;
              state     <= FETCH;
            end
          end else if (ack_valid || timer == ACK_LAST) begin
            if (int'(retry_cnt) < MAX_RETRIES) begin
              retry_cnt <= retry_cnt + 2'd1;
              rom_addr  <= cmd_start;
              state     <= FETCH;
            end else begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= ERROR;
            end
          end
        end
        default: begin
          state <= STARTUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gps_config_sequencer.sv
// tb_gps_config_sequencer: randomized and directed stimulus for the GPS
// configuration sequencer, checked every cycle against a transaction-level
// model of the expected byte stream, ack window and status outputs.
module tb_gps_config_sequencer;

  localparam int SYSCLK_FREQ    = 10_000;
  localparam int STARTUP_MS     = 2;
  localparam int ACK_TIMEOUT_MS = 1;
  localparam int MAX_RETRIES    = 3;
  localparam int NUM_CMDS       = 2;
  localparam int STARTUP_CYCLES = SYSCLK_FREQ / 1000 * STARTUP_MS;
  localparam int ACK_CYCLES     = SYSCLK_FREQ / 1000 * ACK_TIMEOUT_MS;

  typedef logic [7:0] byte_q_t [$];

  logic       sclk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       ack_valid = 1'b0;
  logic       ack_ok = 1'b0;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] cmd_index;
  logic [1:0] retry_cnt;

  logic [7:0] rom [256];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Stimulus controls (written by the main sequence only)
  int ready_mode = 0;
  int ack_mode = 1;
  int fixed_delay = 5;
  bit spur_en = 1'b0;
  bit rand_start = 1'b0;
  int start_reqs = 0;
  int nak_reqs = 0;

  // Driver-owned state
  int start_served = 0;
  int nak_served = 0;
  int cur_delay = 5;
  bit cur_ok = 1'b1;

  // Model state (written by the compare process only)
  logic [7:0] m_addr;
  logic [7:0] m_start_addr;
  int  m_cmd = 0;
  int  m_retry = 0;
  int  m_valid_due = STARTUP_CYCLES + 2;
  int  m_lf_edge = 0;
  bit  m_sending = 1'b0;
  bit  m_awaiting = 1'b0;
  bit  m_done = 1'b0;
  bit  m_error = 1'b0;
  bit  exp_valid;
  bit  prev_hold = 1'b0;
  logic [7:0] prev_data;
  logic [7:0] tx_log [$];
  int  lf_edges [$];
  int  first_valid_cyc = -1;

  byte_q_t exp_q;
  int base;
  int lf_base;

  gps_config_sequencer #(
    .SYSCLK_FREQ   (SYSCLK_FREQ),
    .STARTUP_MS    (STARTUP_MS),
    .ACK_TIMEOUT_MS(ACK_TIMEOUT_MS),
    .MAX_RETRIES   (MAX_RETRIES),
    .NUM_CMDS      (NUM_CMDS)
  ) dut (
    .sclk     (sclk),
    .rstn     (rstn),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ack_valid(ack_valid),
    .ack_ok   (ack_ok),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cmd_index(cmd_index),
    .retry_cnt(retry_cnt)
  );

  always #5 sclk = ~sclk;

  // ROM holding "A\nB\n"
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h41;
    rom[1] = 8'h0A;
    rom[2] = 8'h42;
    rom[3] = 8'h0A;
  end

  // Registered ROM: data follows the address by one clock
  always @(posedge sclk) rom_data <= rom[rom_addr];

  // Cycle count since reset release
  always @(posedge sclk) begin
    if (!rstn) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_log(input string tag, input int from, input byte_q_t exp);
    check_output({tag, "_len"}, 32'(tx_log.size() - from), 32'(exp.size()));
    foreach (exp[i]) begin
      if (from + i < tx_log.size()) check_output({tag, "_byte"}, 32'(tx_log[from + i]), 32'(exp[i]));
    end
  endtask

  task automatic apply_stimulus(input int rmode, input int amode, input int delay, input bit spur, input bit rstart);
    ready_mode  = rmode;
    ack_mode    = amode;
    fixed_delay = delay;
    spur_en     = spur;
    rand_start  = rstart;
  endtask

  task automatic request_start();
    int n = 0;
    start_reqs++;
    while (start_served != start_reqs && n < 10) begin
      @(posedge sclk);
      n++;
    end
    #3;
    check_output("start_served", 32'(start_served), 32'(start_reqs));
  endtask

  task automatic wait_finish(input int budget);
    int n = 0;
    while (!(m_done || m_error) && n < budget) begin
      @(posedge sclk);
      n++;
    end
    #3;
    check_output("finish_in_budget", 32'(m_done || m_error), 32'(1));
  endtask

  // Input driver: runs just after each rising edge
  always @(posedge sclk) begin
    #2;
    start     = 1'b0;
    ack_valid = 1'b0;
    ack_ok    = 1'b0;
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ~tx_ready;
      2: tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
    if (start_served != start_reqs) begin
      start = 1'b1;
      start_served++;
    end else if (rand_start && $urandom_range(0, 59) == 0) begin
      start = 1'b1;
    end
    if (m_awaiting && cyc == m_lf_edge) begin
      if (ack_mode == 2) begin
        cur_delay = int'($urandom_range(1, 13));
        cur_ok    = ($urandom_range(0, 3) != 0);
      end else begin
        cur_delay = fixed_delay;
        cur_ok    = 1'b1;
        if (nak_served != nak_reqs) begin
          cur_ok = 1'b0;
          nak_served++;
        end
      end
    end
    if (ack_mode != 0 && m_awaiting && cyc == m_lf_edge + cur_delay) begin
      ack_valid = 1'b1;
      ack_ok    = cur_ok;
    end else if (spur_en && !m_awaiting && $urandom_range(0, 5) == 0) begin
      ack_valid = 1'b1;
      ack_ok    = 1'($urandom_range(0, 1));
    end
  end

  // Compare process: checks outputs mid-cycle, then advances the model
  always @(negedge sclk) begin
    if (!rstn) begin
      check_output("rst_tx_valid", 32'(tx_valid), 32'(0));
      check_output("rst_tx_data", 32'(tx_data), 32'(0));
      check_output("rst_busy", 32'(busy), 32'(1));
      check_output("rst_done", 32'(done), 32'(0));
      check_output("rst_error", 32'(error), 32'(0));
      check_output("rst_cmd_index", 32'(cmd_index), 32'(0));
      check_output("rst_retry_cnt", 32'(retry_cnt), 32'(0));
      check_output("rst_rom_addr", 32'(rom_addr), 32'(0));
      m_addr = 8'h00;
      m_start_addr = 8'h00;
      m_cmd = 0;
      m_retry = 0;
      m_valid_due = STARTUP_CYCLES + 2;
      m_sending = 1'b0;
      m_awaiting = 1'b0;
      m_done = 1'b0;
      m_error = 1'b0;
      prev_hold = 1'b0;
      first_valid_cyc = -1;
    end else begin
      if (prev_hold) begin
        check_output("hold_tx_valid", 32'(tx_valid), 32'(1));
        check_output("hold_tx_data", 32'(tx_data), 32'(prev_data));
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;

      exp_valid = m_sending || (cyc == m_valid_due);
      check_output("tx_valid", 32'(tx_valid), 32'(exp_valid));
      if (exp_valid) check_output("tx_data", 32'(tx_data), 32'(rom[m_addr]));
      check_output("busy", 32'(busy), 32'(!(m_done || m_error)));
      check_output("done", 32'(done), 32'(m_done));
      check_output("error", 32'(error), 32'(m_error));
      check_output("cmd_index", 32'(cmd_index), 32'(m_cmd));
      check_output("retry_cnt", 32'(retry_cnt), 32'(m_retry));
      check_output("rom_addr", 32'(rom_addr), 32'(m_addr));

      if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (tx_valid && tx_ready) begin
        tx_log.push_back(tx_data);
        if (tx_data == 8'h0A) lf_edges.push_back(cyc + 1);
      end

      if (cyc == m_valid_due) begin
        m_sending = 1'b1;
        m_valid_due = -1;
      end

      if (m_sending && tx_ready) begin
        m_sending = 1'b0;
        if (rom[m_addr] == 8'h0A) begin
          m_awaiting = 1'b1;
          m_lf_edge = cyc + 1;
        end else begin
          m_addr = m_addr + 8'd1;
          m_valid_due = cyc + 3;
        end
      end else if (m_awaiting) begin
        if (ack_valid && ack_ok) begin
          m_awaiting = 1'b0;
          if (m_cmd == NUM_CMDS - 1) begin
            m_done = 1'b1;
          end else begin
            m_cmd++;
            m_retry = 0;
            m_addr = m_addr + 8'd1;
            m_start_addr = m_addr;
            m_valid_due = cyc + 3;
          end
        end else if (ack_valid || (cyc + 1 - m_lf_edge == ACK_CYCLES)) begin
          m_awaiting = 1'b0;
          if (m_retry < MAX_RETRIES) begin
            m_retry++;
            m_addr = m_start_addr;
            m_valid_due = cyc + 3;
          end else begin
            m_error = 1'b1;
          end
        end
      end else if ((m_done || m_error) && start) begin
        m_done = 1'b0;
        m_error = 1'b0;
        m_cmd = 0;
        m_retry = 0;
        m_addr = 8'h00;
        m_start_addr = 8'h00;
        m_valid_due = cyc + 3;
      end
    end
  end

  // Hard stop if the sequence ever stalls completely
  initial begin
    #(1_000_000);
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence of scenarios
  initial begin
    apply_stimulus(0, 1, 5, 1'b0, 1'b0);
    #1 rstn = 1'b0;
    repeat (3) @(posedge sclk);
    #2 rstn = 1'b1;

    // Basic run: two sentences, acks 5 cycles after each LF
    base = tx_log.size();
    wait_finish(300);
    check_output("s1_first_valid_cycle", 32'(first_valid_cyc), 32'(22));
    exp_q = '{8'h41, 8'h0A, 8'h42, 8'h0A};
    check_log("s1", base, exp_q);
    check_output("s1_done", 32'(done), 32'(1));
    check_output("s1_busy", 32'(busy), 32'(0));

    // tx_ready toggling every cycle
    apply_stimulus(1, 1, 5, 1'b0, 1'b0);
    base = tx_log.size();
    request_start();
    wait_finish(300);
    check_log("s2", base, exp_q);
    check_output("s2_done", 32'(done), 32'(1));

    // First ack is a NAK: sentence 0 is resent once
    apply_stimulus(0, 1, 5, 1'b0, 1'b0);
    nak_reqs++;
    base = tx_log.size();
    request_start();
    wait_finish(300);
    exp_q = '{8'h41, 8'h0A, 8'h41, 8'h0A, 8'h42, 8'h0A};
    check_log("s3", base, exp_q);
    check_output("s3_cmd_index", 32'(cmd_index), 32'(1));
    check_output("s3_retry_cnt", 32'(retry_cnt), 32'(0));

    // No acks at all: four sends of sentence 0, then ERROR
    apply_stimulus(0, 0, 5, 1'b0, 1'b0);
    base = tx_log.size();
    lf_base = lf_edges.size();
    request_start();
    wait_finish(400);
    exp_q = '{8'h41, 8'h0A, 8'h41, 8'h0A, 8'h41, 8'h0A, 8'h41, 8'h0A};
    check_log("s4", base, exp_q);
    check_output("s4_lf_count", 32'(lf_edges.size() - lf_base), 32'(4));
    for (int k = lf_base + 1; k < lf_edges.size(); k++) begin
      check_output("s4_lf_spacing", 32'(lf_edges[k] - lf_edges[k - 1]), 32'(16));
    end
    check_output("s4_error", 32'(error), 32'(1));
    check_output("s4_busy", 32'(busy), 32'(0));
    check_output("s4_retry_cnt", 32'(retry_cnt), 32'(3));

    // Spurious acks during startup/send, from a fresh reset
    @(posedge sclk);
    #2 rstn = 1'b0;
    apply_stimulus(0, 1, 5, 1'b1, 1'b0);
    repeat (2) @(posedge sclk);
    #2 rstn = 1'b1;
    base = tx_log.size();
    wait_finish(300);
    exp_q = '{8'h41, 8'h0A, 8'h42, 8'h0A};
    check_log("s5", base, exp_q);
    check_output("s5_first_valid_cycle", 32'(first_valid_cyc), 32'(22));
    check_output("s5_done", 32'(done), 32'(1));

    // Restart from DONE: no startup delay, begins at address 0
    base = tx_log.size();
    request_start();
    check_output("s5_restart_done", 32'(done), 32'(0));
    check_output("s5_restart_busy", 32'(busy), 32'(1));
    @(posedge sclk);
    #3 check_output("s5_restart_load_valid", 32'(tx_valid), 32'(0));
    @(posedge sclk);
    #3 check_output("s5_restart_valid", 32'(tx_valid), 32'(1));
    check_output("s5_restart_data", 32'(tx_data), 32'(8'h41));
    check_output("s5_restart_addr", 32'(rom_addr), 32'(0));
    wait_finish(300);
    check_log("s5r", base, exp_q);

    // Reset in the middle of a stalled send
    apply_stimulus(3, 1, 5, 1'b0, 1'b0);
    request_start();
    for (int n = 0; n < 10 && !tx_valid; n++) begin
      @(posedge sclk);
      #3;
    end
    check_output("s6_stalled_valid", 32'(tx_valid), 32'(1));
    @(posedge sclk);
    #2 rstn = 1'b0;
    #1 check_output("s6_async_drop", 32'(tx_valid), 32'(0));
    apply_stimulus(0, 1, 5, 1'b0, 1'b0);
    repeat (2) @(posedge sclk);
    #2 rstn = 1'b1;
    base = tx_log.size();
    wait_finish(300);
    check_output("s6_first_valid_cycle", 32'(first_valid_cyc), 32'(22));
    check_log("s6", base, exp_q);
    check_output("s6_done", 32'(done), 32'(1));

    // Randomized traffic: ready, ack timing/outcome, spurious acks, starts
    apply_stimulus(2, 2, 0, 1'b1, 1'b1);
    repeat (4000) @(posedge sclk);
    apply_stimulus(0, 1, 5, 1'b0, 1'b0);
    wait_finish(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gps_config_sequencer.md
# gps_config_sequencer

Sequences the GPS receiver's configuration after power-up. It holds off for a startup delay, then streams a list of LF-terminated command sentences from a byte ROM into the GPS UART transmitter over a valid/ready handshake. After each sentence it waits for an acknowledge decoded by the NMEA parser, retrying on NAK or timeout. It sits beside the NMEA parser inside the GPS wrapper and owns the receiver's TX path.

## Interface
- SYSCLK_FREQ, 100_000_000, clock frequency in Hz
- STARTUP_MS, 1000, delay after reset before the first byte is sent
- ACK_TIMEOUT_MS, 500, wait limit for an ack after each sentence's LF
- MAX_RETRIES, 3, resends allowed per sentence before ERROR
- NUM_CMDS, 4, number of LF-terminated sentences in the ROM, 1..255
- sclk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; reruns the sequence from sentence 0 (no startup delay); honoured only in IDLE, DONE, ERROR
- rom_addr  out  8  ROM byte address
- rom_data  in  8  ROM byte; valid exactly 1 cycle after rom_addr changes (registered ROM)
- tx_data  out  8  byte to the UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts; transfer when tx_valid && tx_ready
- ack_valid  in  1  one-cycle pulse from the parser: an acknowledge sentence was decoded
- ack_ok  in  1  qualifies ack_valid: 1 = success, 0 = failure/unsupported
- busy  out  1  high in every state except IDLE, DONE, ERROR
- done  out  1  high in DONE
- error  out  1  high in ERROR
- cmd_index  out  8  sentence currently being sent or awaited
- retry_cnt  out  2  resends used on the current sentence

## Operation
- States: IDLE, STARTUP, FETCH, LOAD, SEND, WAIT_ACK, DONE, ERROR.
- Reset: state STARTUP; rom_addr=0, tx_data=0, tx_valid=0, cmd_index=0, retry_cnt=0, done=0, error=0, busy=1. Timer cleared.
- STARTUP: count STARTUP_CYCLES = SYSCLK_FREQ/1000*STARTUP_MS. On terminal count, go to FETCH with rom_addr=0 and cmd_start=0.
- FETCH: rom_addr is stable; go to LOAD.
- LOAD: tx_data <= rom_data; tx_valid <= 1; go to SEND.
- SEND: hold tx_valid and tx_data until tx_ready is high. On transfer, drop tx_valid.
  - If the byte was 0x0A: clear the timer and go to WAIT_ACK.
  - Otherwise: rom_addr+1 and go to FETCH.
- WAIT_ACK: timer counts ACK_CYCLES = SYSCLK_FREQ/1000*ACK_TIMEOUT_MS.
  - ack_valid && ack_ok:
    - Last sentence (cmd_index == NUM_CMDS-1): go to DONE.
    - Otherwise: cmd_index+1, retry_cnt=0, rom_addr+1, cmd_start <= rom_addr+1, go to FETCH.
  - ack_valid && !ack_ok, or terminal count:
    - retry_cnt < MAX_RETRIES: retry_cnt+1, rom_addr <= cmd_start, go to FETCH.
    - Otherwise: go to ERROR.
  - ack_valid and terminal count in the same cycle: ack_valid wins.
- ack_valid outside WAIT_ACK is ignored, not queued.
- DONE and ERROR hold until start. start from IDLE, DONE or ERROR clears done, error, cmd_index, retry_cnt and rom_addr, then goes to FETCH.
- start while busy is ignored.
- rom_addr wraps mod 256; a ROM longer than 256 bytes is unsupported.
- Timer width is clog2 of max(STARTUP_CYCLES, ACK_CYCLES)+1. The timer saturates, never wraps.

## Timing
- Per byte, minimum 3 cycles (FETCH, LOAD, SEND with tx_ready=1); each tx_ready-low cycle adds one.
- First tx_valid rises STARTUP_CYCLES+2 cycles after rstn deasserts.
- After start, tx_valid rises 2 cycles later.
- Ack accepted in cycle N: the next sentence's tx_valid rises at N+3.
- Timeout fires ACK_CYCLES cycles after the LF transfer cycle.
- tx_data never changes while tx_valid && !tx_ready.
- Reset mid-operation returns to STARTUP immediately and drops tx_valid asynchronously.

## Test plan
- SYSCLK_FREQ=10_000, STARTUP_MS=2, ROM "A\nB\n", NUM_CMDS=2, tx_ready=1, ack_ok pulse 5 cycles after each LF -> first tx_valid at cycle 22; bytes 0x41,0x0A,0x42,0x0A; done=1, busy=0.
- Same setup, tx_ready toggling 0/1 each cycle -> tx_data stable while tx_ready=0; each byte transferred exactly once.
- First ack has ack_ok=0 -> retry_cnt=1; bytes 0x41,0x0A resent; ack_ok=1 -> cmd_index=1, retry_cnt=0.
- No acks, MAX_RETRIES=3, ACK_TIMEOUT_MS=1 -> sentence 0 sent 4 times, 10 cycles apart after each LF; error=1, busy=0.
- ack_valid pulsed during STARTUP and SEND -> ignored; sequence completes normally. Then start pulse in DONE -> done=0, resend from address 0 with no startup delay.
- rstn pulled low during SEND with tx_ready=0 -> tx_valid=0 immediately; after release, STARTUP delay repeats and output matches the first scenario.
